// File: rtl/cond_pkg.sv
// Shared types for the condition/execute stage: ARMv4 condition codes, NZCV flags,
// the EX/MEM register state, and the condition evaluator function.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
        MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
        HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
        GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } reg_state_e;

    function automatic logic cond_pass(input cond_e cc, input flags_t f);
        logic pass;
        pass = 1'b0;
        case (cc)
            EQ: pass = f.z;
            NE: pass = !f.z;
            CS: pass = f.c;
            CC: pass = !f.c;
            MI: pass = f.n;
            PL: pass = !f.n;
            VS: pass = f.v;
            VC: pass = !f.v;
            HI: pass = f.c & !f.z;
            LS: pass = !f.c | f.z;
            GE: pass = (f.n == f.v);
            LT: pass = (f.n != f.v);
            GT: pass = !f.z & (f.n == f.v);
            LE: pass = f.z | (f.n != f.v);
            AL: pass = 1'b1;
            NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/cond_exec_stage_if.sv
// Execute-side and memory-side handshake bundle of the condition/execute stage.
// master = surrounding pipeline, slave = cond_exec_stage.
interface cond_exec_stage_if #(
    parameter int N  = 32,
    parameter int RW = 4
);
    logic          ex_valid;
    logic          ex_ready;
    logic [3:0]    cond;
    logic [1:0]    flag_w;
    logic [N-1:0]  alu_result;
    logic [3:0]    alu_flags;
    logic [RW-1:0] rd;
    logic          pcs;
    logic          reg_w;
    logic          mem_w;
    logic          no_write;
    logic          flush;

    logic          mem_valid;
    logic          mem_ready;
    logic [N-1:0]  mem_result;
    logic [RW-1:0] mem_rd;
    logic          mem_reg_write;
    logic          mem_mem_write;
    logic          mem_pc_src;

    modport master (
        output ex_valid, cond, flag_w, alu_result, alu_flags, rd,
               pcs, reg_w, mem_w, no_write, flush, mem_ready,
        input  ex_ready, mem_valid, mem_result, mem_rd,
               mem_reg_write, mem_mem_write, mem_pc_src
    );

    modport slave (
        input  ex_valid, cond, flag_w, alu_result, alu_flags, rd,
               pcs, reg_w, mem_w, no_write, flush, mem_ready,
        output ex_ready, mem_valid, mem_result, mem_rd,
               mem_reg_write, mem_mem_write, mem_pc_src
    );
endinterface

// File: rtl/cond_check.sv
// Pure combinational ARMv4 condition evaluator.
module cond_check
    import cond_pkg::*;
(
    input  cond_e  cond,
    input  flags_t flags,
    output logic   pass
);
    assign pass = cond_pass(cond, flags);
endmodule

// File: rtl/cond_exec_stage.sv
// EX->MEM boundary: NZCV flag register, condition gating of writes, EX/MEM register.
// Optional COND_SQUASH_CNT_EN adds a saturating squashed-instruction counter.
//
// state    | meaning
// ST_EMPTY | EX/MEM register holds no instruction
// ST_FULL  | EX/MEM register holds an instruction for the memory stage
module cond_exec_stage
    import cond_pkg::*;
#(
    parameter int N  = 32,
    parameter int RW = 4
) (
    input  logic              clk,
    input  logic              reset,
    cond_exec_stage_if.slave  bus,
    output logic [3:0]        flags_q,
`ifdef COND_SQUASH_CNT_EN
    output logic [15:0]       squash_cnt,
`endif
    output logic              cond_ex
);

    reg_state_e    state_q, state_d;
    logic          ready;
    logic          accept;
    flags_t        flags_r;
    logic [N-1:0]  result_q;
    logic [RW-1:0] rd_q;
    logic          reg_write_q, mem_write_q, pc_src_q;

    cond_check u_cond_check (
        .cond  (cond_e'(bus.cond)),
        .flags (flags_r),
        .pass  (cond_ex)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = (state_q == ST_EMPTY) | bus.mem_ready;
        accept  = bus.ex_valid & ready & !bus.flush;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL: begin
                if (accept)             state_d = ST_FULL;
                else if (bus.mem_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Result/rd keep their last value once consumed; only the write enables are cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
        end else if (accept) begin
            result_q    <= bus.alu_result;
            rd_q        <= bus.rd;
            reg_write_q <= bus.reg_w & cond_ex & !bus.no_write;
            mem_write_q <= bus.mem_w & cond_ex;
            pc_src_q    <= bus.pcs & cond_ex;
        end else if (bus.mem_ready) begin
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r <= '0;
        end else if (accept && cond_ex) begin
            if (bus.flag_w[1]) begin
                flags_r.n <= bus.alu_flags[3];
                flags_r.z <= bus.alu_flags[2];
            end
            if (bus.flag_w[0]) begin
                flags_r.c <= bus.alu_flags[1];
                flags_r.v <= bus.alu_flags[0];
            end
        end
    end

`ifdef COND_SQUASH_CNT_EN
    logic [15:0] squash_q;

    always_ff @(posedge clk) begin
        if (reset)
            squash_q <= '0;
        else if (accept && !cond_ex && squash_q != 16'hFFFF)
            squash_q <= squash_q + 16'd1;
    end

    assign squash_cnt = squash_q;
`endif

    assign flags_q           = flags_r;
    assign bus.ex_ready      = ready;
    assign bus.mem_valid     = (state_q == ST_FULL);
    assign bus.mem_result    = result_q;
    assign bus.mem_rd        = rd_q;
    assign bus.mem_reg_write = reg_write_q;
    assign bus.mem_mem_write = mem_write_q;
    assign bus.mem_pc_src    = pc_src_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Self-checking bench for cond_exec_stage: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the stage.
module tb_cond_exec_stage;

    logic clk;
    logic reset;
    logic [3:0] flags_q;
    logic cond_ex;
`ifdef COND_SQUASH_CNT_EN
    logic [15:0] squash_cnt;
`endif

    cond_exec_stage_if #(.N(32), .RW(4)) bus ();

    cond_exec_stage #(.N(32), .RW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .flags_q    (flags_q),
`ifdef COND_SQUASH_CNT_EN
        .squash_cnt (squash_cnt),
`endif
        .cond_ex    (cond_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit        m_valid;
    bit [31:0] m_result;
    bit [3:0]  m_rd;
    bit        m_rw, m_mw, m_pc;
    bit [3:0]  m_flags;
    int        m_sq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ARMv4 encoding: cond[3:1] selects a base predicate, cond[0] inverts it.
    function automatic bit ref_cond(input bit [3:0] cc, input bit [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (cc == 4'd14) return 1'b1;
        if (cc == 4'd15) return 1'b0;
        case (cc >> 1)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return cc[0] ? !base : base;
    endfunction

    task automatic drive(input bit ev, input bit [3:0] cc, input bit [1:0] fw, input bit [3:0] af,
                         input bit [31:0] res, input bit [3:0] rdi, input bit pcs, input bit rw,
                         input bit mw, input bit nw, input bit fl, input bit mr);
        bus.ex_valid   = ev;
        bus.cond       = cc;
        bus.flag_w     = fw;
        bus.alu_flags  = af;
        bus.alu_result = res;
        bus.rd         = rdi;
        bus.pcs        = pcs;
        bus.reg_w      = rw;
        bus.mem_w      = mw;
        bus.no_write   = nw;
        bus.flush      = fl;
        bus.mem_ready  = mr;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic do_cycle();
        bit rdy, pass, acc;
        #1;
        rdy  = !m_valid || bus.mem_ready;
        pass = ref_cond(bus.cond, m_flags);
        acc  = bus.ex_valid && rdy && !bus.flush;
        check("ex_ready", bus.ex_ready, rdy);
        check("cond_ex", cond_ex, pass);
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 0; m_result = 0; m_rd = 0;
            m_rw = 0; m_mw = 0; m_pc = 0; m_flags = 0; m_sq = 0;
        end else if (acc) begin
            m_valid  = 1;
            m_result = bus.alu_result;
            m_rd     = bus.rd;
            m_rw     = bus.reg_w && pass && !bus.no_write;
            m_mw     = bus.mem_w && pass;
            m_pc     = bus.pcs && pass;
            if (pass) begin
                if (bus.flag_w[1]) m_flags[3:2] = bus.alu_flags[3:2];
                if (bus.flag_w[0]) m_flags[1:0] = bus.alu_flags[1:0];
            end else if (m_sq < 65535) begin
                m_sq++;
            end
        end else if (bus.mem_ready) begin
            m_valid = 0; m_rw = 0; m_mw = 0; m_pc = 0;
        end
        check("mem_valid", bus.mem_valid, m_valid);
        check("mem_result", bus.mem_result, m_result);
        check("mem_rd", bus.mem_rd, m_rd);
        check("mem_reg_write", bus.mem_reg_write, m_rw);
        check("mem_mem_write", bus.mem_mem_write, m_mw);
        check("mem_pc_src", bus.mem_pc_src, m_pc);
        check("flags_q", flags_q, m_flags);
`ifdef COND_SQUASH_CNT_EN
        check("squash_cnt", squash_cnt, m_sq[15:0]);
`endif
    endtask

    initial begin
        bit [3:0] saved_flags;

        reset = 1'b1;
        drive(1, 4'd14, 2'b11, 4'hF, 32'h1234, 4'd3, 1, 1, 1, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_valid = 0; m_result = 0; m_rd = 0;
        m_rw = 0; m_mw = 0; m_pc = 0; m_flags = 0; m_sq = 0;
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_flags", flags_q, 4'h0);
        check("rst_ex_ready", bus.ex_ready, 1'b1);
        reset = 1'b0;

        // CMP sets Z, then EQ passes and NE fails
        drive(1, 4'd14, 2'b11, 4'b0100, 32'h0, 4'd0, 0, 1, 0, 1, 0, 1);
        do_cycle();
        check("cmp_flags", flags_q, 4'b0100);
        drive(1, 4'd0, 2'b00, 4'h0, 32'h5, 4'd2, 0, 1, 0, 0, 0, 1);
        do_cycle();
        check("eq_reg_write", bus.mem_reg_write, 1'b1);
        check("eq_result", bus.mem_result, 32'h5);
        drive(1, 4'd1, 2'b00, 4'h0, 32'h6, 4'd2, 0, 1, 0, 0, 0, 1);
        do_cycle();
        check("ne_reg_write", bus.mem_reg_write, 1'b0);

        // NV never writes anything
        drive(1, 4'd15, 2'b11, 4'b1111, 32'h7, 4'd1, 1, 1, 1, 0, 0, 1);
        do_cycle();
        check("nv_flags", flags_q, 4'b0100);
        check("nv_ctrl", {bus.mem_reg_write, bus.mem_mem_write, bus.mem_pc_src}, 3'b000);

        // stall for 3 cycles behind a held entry
        drive(1, 4'd14, 2'b00, 4'h0, 32'hAA, 4'd4, 0, 1, 0, 0, 0, 1);
        do_cycle();
        saved_flags = flags_q;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd14, 2'b11, 4'b1010, 32'hBB + i, 4'd5, 0, 1, 1, 0, 0, 0);
            do_cycle();
            check("stall_ex_ready", bus.ex_ready, 1'b0);
            check("stall_result", bus.mem_result, 32'hAA);
            check("stall_flags", flags_q, saved_flags);
        end

        // flush while ready
        drive(1, 4'd14, 2'b11, 4'b1011, 32'hCC, 4'd6, 1, 1, 1, 0, 1, 1);
        do_cycle();
        check("flush_valid", bus.mem_valid, 1'b0);
        check("flush_flags", flags_q, saved_flags);

        // reset while stalled discards the entry
        drive(1, 4'd14, 2'b00, 4'h0, 32'hDD, 4'd7, 0, 1, 0, 0, 0, 1);
        do_cycle();
        drive(1, 4'd14, 2'b00, 4'h0, 32'hEE, 4'd7, 0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        do_cycle();
        reset = 1'b0;
        check("rst_stall_valid", bus.mem_valid, 1'b0);

`ifdef COND_SQUASH_CNT_EN
        // flags are zero after reset, so N==V and LT fails
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'd11, 2'b00, 4'h0, 32'h100 + i, 4'd1, 0, 1, 0, 0, 0, 1);
            do_cycle();
        end
        check("squash_five", squash_cnt, 16'd5);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 4'($urandom),
                  $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 6);
            do_cycle();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
